// File: rtl/rv32_types_pkg.sv
// rtl/rv32_types_pkg.sv - shared types between the decode and execute stages
package rv32_types;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASS_B
    } alu_op_t;

    typedef enum logic [2:0] {
        BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU
    } branch_op_t;

    typedef enum logic [1:0] {
        OP1_REG1, OP1_PC, OP1_ZERO
    } op1_sel_t;

    typedef enum logic {
        OP2_REG2, OP2_IMM
    } op2_sel_t;

    typedef struct packed {
        logic [31:0] instr;
        alu_op_t     alu_op;
        op1_sel_t    op1_sel;
        op2_sel_t    op2_sel;
        logic [31:0] imm;
        branch_op_t  branch_op;
        logic        jal;
        logic        jalr;
        logic        wb_en;
        logic [4:0]  rd;
    } decoded_instr_t;

    typedef struct packed {
        decoded_instr_t decoded_instr;
        logic [31:0]    pc;
        logic [31:0]    reg1;
        logic [31:0]    reg2;
    } decoded_buffer_data_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] result;
        logic [31:0] store_data;
        logic [4:0]  rd;
        logic        wb_en;
        logic        valid;
        logic        misaligned;
    } exec_buffer_data_t;

endpackage

// File: rtl/rv32_int_alu.sv
// rtl/rv32_int_alu.sv - combinational integer ALU
module rv32_int_alu
    import rv32_types::*;
(
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  alu_op_t     opsel,
    output logic [31:0] result
);

    logic [4:0] shamt;
    assign shamt = op2[4:0];

    always_comb begin
        result = 32'h0;
        case (opsel)
            ALU_ADD:    result = op1 + op2;
            ALU_SUB:    result = op1 - op2;
            ALU_SLL:    result = op1 << shamt;
            ALU_SLT:    result = {31'h0, $signed(op1) < $signed(op2)};
            ALU_SLTU:   result = {31'h0, op1 < op2};
            ALU_XOR:    result = op1 ^ op2;
            ALU_SRL:    result = op1 >> shamt;
            ALU_SRA:    result = $unsigned($signed(op1) >>> shamt);
            ALU_OR:     result = op1 | op2;
            ALU_AND:    result = op1 & op2;
            ALU_PASS_B: result = op2;
            default:    result = 32'h0;
        endcase
    end

endmodule

// File: rtl/rv32_exec_stage.sv
// rtl/rv32_exec_stage.sv - execute stage: ALU, branch resolution, redirect and squash
module rv32_exec_stage
    import rv32_types::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  decoded_buffer_data_t dec_data,
    input  logic                 dec_valid,
    input  logic                 stall_in,
    output logic                 stall_out,
    output exec_buffer_data_t    exec_data,
    output logic                 redirect,
    output logic [31:0]          redirect_pc,
    output logic [63:0]          instret
);

    decoded_instr_t di;
    logic [31:0]    op1;
    logic [31:0]    op2;
    logic [31:0]    alu_result;
    logic           br_cond;
    logic           taken;
    logic [31:0]    target;
    logic           misaligned;
    exec_buffer_data_t computed;

    exec_buffer_data_t exec_q, exec_d;
    logic              redirect_q, redirect_d;
    logic [31:0]       redirect_pc_q, redirect_pc_d;
    logic [63:0]       instret_q, instret_d;

    assign di = dec_data.decoded_instr;

    always_comb begin
        op1 = dec_data.reg1;
        case (di.op1_sel)
            OP1_PC:   op1 = dec_data.pc;
            OP1_ZERO: op1 = 32'h0;
            default:  op1 = dec_data.reg1;
        endcase
        op2 = (di.op2_sel == OP2_IMM) ? di.imm : dec_data.reg2;
    end

    rv32_int_alu u_alu (
        .op1    (op1),
        .op2    (op2),
        .opsel  (di.alu_op),
        .result (alu_result)
    );

    // Branches always compare the raw register operands, independent of op1/op2 muxing.
    always_comb begin
        br_cond = 1'b0;
        case (di.branch_op)
            BR_EQ:   br_cond = dec_data.reg1 == dec_data.reg2;
            BR_NE:   br_cond = dec_data.reg1 != dec_data.reg2;
            BR_LT:   br_cond = $signed(dec_data.reg1) < $signed(dec_data.reg2);
            BR_GE:   br_cond = $signed(dec_data.reg1) >= $signed(dec_data.reg2);
            BR_LTU:  br_cond = dec_data.reg1 < dec_data.reg2;
            BR_GEU:  br_cond = dec_data.reg1 >= dec_data.reg2;
            default: br_cond = 1'b0;
        endcase
    end

    assign target     = di.jalr ? ((dec_data.reg1 + di.imm) & ~32'h1) : (dec_data.pc + di.imm);
    assign taken      = dec_valid & (di.jal | di.jalr | br_cond);
    assign misaligned = taken & (target[1:0] != 2'b00);

    always_comb begin
        computed            = '0;
        computed.pc         = dec_data.pc;
        computed.instr      = di.instr;
        computed.result     = (di.jal | di.jalr) ? (dec_data.pc + 32'd4) : alu_result;
        computed.store_data = dec_data.reg2;
        computed.rd         = di.rd;
        computed.valid      = dec_valid;
        computed.misaligned = misaligned;
        computed.wb_en      = di.wb_en & dec_valid & ~misaligned;
    end

    always_comb begin
        exec_d        = exec_q;
        redirect_d    = 1'b0;
        redirect_pc_d = redirect_pc_q;
        instret_d     = instret_q;
        if (exec_q.valid && !stall_in) begin
            instret_d = instret_q + 64'd1;
        end
        if (!stall_in) begin
            if (redirect_q) begin
                // Wrong-path slot behind a taken transfer is turned into a bubble.
                exec_d            = computed;
                exec_d.valid      = 1'b0;
                exec_d.wb_en      = 1'b0;
                exec_d.misaligned = 1'b0;
            end else begin
                exec_d        = computed;
                redirect_d    = taken;
                redirect_pc_d = target;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            exec_q        <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= RESET_PC;
            instret_q     <= 64'h0;
        end else begin
            exec_q        <= exec_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
            instret_q     <= instret_d;
        end
    end

    assign stall_out   = stall_in;
    assign exec_data   = exec_q;
    assign redirect    = redirect_q;
    assign redirect_pc = redirect_pc_q;
    assign instret     = instret_q;

endmodule

// File: tb/tb_rv32_exec_stage.sv
// tb/tb_rv32_exec_stage.sv - directed self-checking bench for rv32_exec_stage
module tb_rv32_exec_stage;
    import rv32_types::*;

    localparam logic [31:0] RST_PC = 32'h0000_1000;

    logic                 clk = 1'b0;
    logic                 resetn;
    decoded_buffer_data_t dec_data;
    logic                 dec_valid;
    logic                 stall_in;
    logic                 stall_out;
    exec_buffer_data_t    exec_data;
    logic                 redirect;
    logic [31:0]          redirect_pc;
    logic [63:0]          instret;

    int checks = 0;
    int errors = 0;

    rv32_exec_stage #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .dec_data    (dec_data),
        .dec_valid   (dec_valid),
        .stall_in    (stall_in),
        .stall_out   (stall_out),
        .exec_data   (exec_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instret     (instret)
    );

    always #5 clk = ~clk;

    function automatic decoded_buffer_data_t mk(
        input alu_op_t aop, input op1_sel_t s1, input op2_sel_t s2, input logic [31:0] imm,
        input branch_op_t bop, input logic jal, input logic jalr, input logic wb,
        input logic [4:0] rd, input logic [31:0] pc, input logic [31:0] r1, input logic [31:0] r2);
        decoded_buffer_data_t d;
        d = '0;
        d.decoded_instr.instr     = pc ^ 32'h0000_0013;
        d.decoded_instr.alu_op    = aop;
        d.decoded_instr.op1_sel   = s1;
        d.decoded_instr.op2_sel   = s2;
        d.decoded_instr.imm       = imm;
        d.decoded_instr.branch_op = bop;
        d.decoded_instr.jal       = jal;
        d.decoded_instr.jalr      = jalr;
        d.decoded_instr.wb_en     = wb;
        d.decoded_instr.rd        = rd;
        d.pc   = pc;
        d.reg1 = r1;
        d.reg2 = r2;
        return d;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn    = 1'b0;
        dec_valid = 1'b0;
        stall_in  = 1'b0;
        dec_data  = '0;
        step();
        resetn = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (exec_data !== '0) begin errors++; $display("FAIL reset_exec got %h want 0", exec_data); end
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL reset_redirect got %b want 0", redirect); end
        checks++; if (redirect_pc !== RST_PC) begin errors++; $display("FAIL reset_redirect_pc got %h want %h", redirect_pc, RST_PC); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
        checks++; if (stall_out !== 1'b0) begin errors++; $display("FAIL reset_stall_out got %b want 0", stall_out); end
    endtask

    task automatic test_add();
        dec_data  = mk(ALU_ADD, OP1_REG1, OP2_REG2, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd5, 32'h10, 32'hFFFF_FFFF, 32'd1);
        dec_valid = 1'b1;
        step();
        checks++; if (exec_data.result !== 32'h0) begin errors++; $display("FAIL add_result got %h want 0", exec_data.result); end
        checks++; if (exec_data.valid !== 1'b1 || exec_data.wb_en !== 1'b1) begin errors++; $display("FAIL add_valid_wb got %b%b want 11", exec_data.valid, exec_data.wb_en); end
        checks++; if (exec_data.rd !== 5'd5 || exec_data.store_data !== 32'd1) begin errors++; $display("FAIL add_rd_store got %0d %h want 5 1", exec_data.rd, exec_data.store_data); end
        checks++; if (instret !== 64'd0) begin errors++; $display("FAIL add_instret_early got %0d want 0", instret); end
        dec_valid = 1'b0;
        step();
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL add_instret got %0d want 1", instret); end
        checks++; if (exec_data.valid !== 1'b0 || exec_data.wb_en !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b%b want 00", exec_data.valid, exec_data.wb_en); end
    endtask

    task automatic test_alu_ops();
        dec_valid = 1'b1;
        dec_data  = mk(ALU_SRA, OP1_REG1, OP2_IMM, 32'd35, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd1, 32'h20, 32'h8000_0000, 32'd0);
        step();
        checks++; if (exec_data.result !== 32'hF000_0000) begin errors++; $display("FAIL sra got %h want f0000000", exec_data.result); end
        dec_data = mk(ALU_SRL, OP1_REG1, OP2_IMM, 32'd35, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd1, 32'h24, 32'h8000_0000, 32'd0);
        step();
        checks++; if (exec_data.result !== 32'h1000_0000) begin errors++; $display("FAIL srl got %h want 10000000", exec_data.result); end
        dec_data = mk(ALU_SUB, OP1_REG1, OP2_REG2, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd1, 32'h28, 32'd0, 32'd1);
        step();
        checks++; if (exec_data.result !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sub got %h want ffffffff", exec_data.result); end
        dec_data = mk(ALU_SLT, OP1_REG1, OP2_REG2, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd1, 32'h2C, 32'd1, 32'hFFFF_FFFF);
        step();
        checks++; if (exec_data.result !== 32'd0) begin errors++; $display("FAIL slt got %h want 0", exec_data.result); end
        dec_data = mk(ALU_SLTU, OP1_REG1, OP2_REG2, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd1, 32'h30, 32'd1, 32'hFFFF_FFFF);
        step();
        checks++; if (exec_data.result !== 32'd1) begin errors++; $display("FAIL sltu got %h want 1", exec_data.result); end
        dec_data = mk(ALU_ADD, OP1_PC, OP2_IMM, 32'h0000_0100, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd1, 32'h34, 32'd7, 32'd0);
        step();
        checks++; if (exec_data.result !== 32'h134) begin errors++; $display("FAIL auipc_add got %h want 134", exec_data.result); end
        dec_valid = 1'b0;
        step();
    endtask

    task automatic test_branch();
        dec_valid = 1'b1;
        dec_data  = mk(ALU_ADD, OP1_REG1, OP2_REG2, 32'h20, BR_LT, 1'b0, 1'b0, 1'b0, 5'd0, 32'h100, 32'hFFFF_FFFF, 32'd0);
        step();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h120) begin errors++; $display("FAIL blt_redirect got %b %h want 1 120", redirect, redirect_pc); end
        checks++; if (exec_data.valid !== 1'b1 || exec_data.wb_en !== 1'b0) begin errors++; $display("FAIL blt_exec got %b%b want 10", exec_data.valid, exec_data.wb_en); end
        dec_data = mk(ALU_ADD, OP1_REG1, OP2_REG2, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd3, 32'h104, 32'd1, 32'd2);
        step();
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL blt_pulse_len got %b want 0", redirect); end
        checks++; if (exec_data.valid !== 1'b0 || exec_data.wb_en !== 1'b0) begin errors++; $display("FAIL squash got %b%b want 00", exec_data.valid, exec_data.wb_en); end
        dec_data = mk(ALU_ADD, OP1_REG1, OP2_REG2, 32'h20, BR_LTU, 1'b0, 1'b0, 1'b0, 5'd0, 32'h108, 32'hFFFF_FFFF, 32'd0);
        step();
        checks++; if (redirect !== 1'b0 || exec_data.valid !== 1'b1) begin errors++; $display("FAIL bltu got redirect %b valid %b want 0 1", redirect, exec_data.valid); end
        dec_valid = 1'b0;
        step();
    endtask

    task automatic test_jalr();
        dec_valid = 1'b1;
        dec_data  = mk(ALU_ADD, OP1_REG1, OP2_IMM, 32'd0, BR_NONE, 1'b0, 1'b1, 1'b1, 5'd1, 32'h40, 32'h203, 32'd0);
        step();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h202) begin errors++; $display("FAIL jalr_redirect got %b %h want 1 202", redirect, redirect_pc); end
        checks++; if (exec_data.misaligned !== 1'b1 || exec_data.wb_en !== 1'b0) begin errors++; $display("FAIL jalr_misaligned got %b wb %b want 1 0", exec_data.misaligned, exec_data.wb_en); end
        checks++; if (exec_data.result !== 32'h44) begin errors++; $display("FAIL jalr_result got %h want 44", exec_data.result); end
        dec_valid = 1'b0;
        step();
        step();
    endtask

    task automatic test_stall();
        do_reset();
        dec_valid = 1'b1;
        dec_data  = mk(ALU_ADD, OP1_REG1, OP2_REG2, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd4, 32'h200, 32'd10, 32'd20);
        step();
        dec_data = mk(ALU_ADD, OP1_REG1, OP2_REG2, 32'd0, BR_NONE, 1'b0, 1'b0, 1'b1, 5'd4, 32'h204, 32'd1, 32'd1);
        stall_in = 1'b1;
        #1;
        checks++; if (stall_out !== 1'b1) begin errors++; $display("FAIL stall_out got %b want 1", stall_out); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (exec_data.pc !== 32'h200 || exec_data.result !== 32'd30 || exec_data.valid !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d got pc %h res %h want 200 1e", i, exec_data.pc, exec_data.result);
            end
            checks++; if (instret !== 64'd0) begin errors++; $display("FAIL stall_instret%0d got %0d want 0", i, instret); end
        end
        stall_in = 1'b0;
        step();
        checks++; if (exec_data.pc !== 32'h204 || exec_data.result !== 32'd2) begin errors++; $display("FAIL stall_release got pc %h res %h want 204 2", exec_data.pc, exec_data.result); end
        checks++; if (instret !== 64'd1) begin errors++; $display("FAIL stall_release_instret got %0d want 1", instret); end
        dec_valid = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        dec_valid = 1'b1;
        dec_data  = mk(ALU_ADD, OP1_PC, OP2_IMM, 32'h10, BR_NONE, 1'b1, 1'b0, 1'b1, 5'd1, 32'h300, 32'd0, 32'd0);
        step();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h310) begin errors++; $display("FAIL b2b_first got %b %h want 1 310", redirect, redirect_pc); end
        dec_data = mk(ALU_ADD, OP1_PC, OP2_IMM, 32'h40, BR_NONE, 1'b1, 1'b0, 1'b1, 5'd1, 32'h304, 32'd0, 32'd0);
        step();
        checks++; if (redirect !== 1'b0 || redirect_pc !== 32'h310 || exec_data.valid !== 1'b0) begin
            errors++; $display("FAIL b2b_second got %b %h v%b want 0 310 0", redirect, redirect_pc, exec_data.valid);
        end
        dec_data = mk(ALU_ADD, OP1_PC, OP2_IMM, 32'h8, BR_NONE, 1'b1, 1'b0, 1'b1, 5'd1, 32'h400, 32'd0, 32'd0);
        step();
        checks++; if (redirect !== 1'b1 || redirect_pc !== 32'h408) begin errors++; $display("FAIL jal_redirect got %b %h want 1 408", redirect, redirect_pc); end
        stall_in = 1'b1;
        dec_data = mk(ALU_ADD, OP1_PC, OP2_IMM, 32'h8, BR_NONE, 1'b1, 1'b0, 1'b1, 5'd1, 32'h408, 32'd0, 32'd0);
        step();
        checks++; if (redirect !== 1'b0 || exec_data.pc !== 32'h400 || exec_data.valid !== 1'b1 || exec_data.result !== 32'h404) begin
            errors++; $display("FAIL stall_redirect got %b pc %h v%b res %h want 0 400 1 404", redirect, exec_data.pc, exec_data.valid, exec_data.result);
        end
        stall_in  = 1'b0;
        dec_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        dec_valid = 1'b1;
        dec_data  = mk(ALU_ADD, OP1_PC, OP2_IMM, 32'h100, BR_NONE, 1'b1, 1'b0, 1'b1, 5'd1, 32'h500, 32'd0, 32'd0);
        step();
        checks++; if (redirect !== 1'b1 || instret === 64'd0) begin errors++; $display("FAIL premid got redirect %b instret %0d want 1 nonzero", redirect, instret); end
        resetn = 1'b0;
        step();
        checks++; if (redirect !== 1'b0 || exec_data.valid !== 1'b0) begin errors++; $display("FAIL mid_reset got %b v%b want 0 0", redirect, exec_data.valid); end
        checks++; if (instret !== 64'd0 || redirect_pc !== RST_PC) begin errors++; $display("FAIL mid_reset_state got %0d %h want 0 %h", instret, redirect_pc, RST_PC); end
        resetn    = 1'b1;
        dec_valid = 1'b0;
        step();
        checks++; if (redirect !== 1'b0) begin errors++; $display("FAIL post_reset_redirect got %b want 0", redirect); end
    endtask

    initial begin
        test_reset();
        test_add();
        test_alu_ops();
        test_branch();
        test_jalr();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
